// File: rtl/jtopll_mmr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : jtopll_mmr
// Description : CPU write port for the OPLL register file. Decodes writes
//               into held update strobes and stores the rhythm controls.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module jtopll_mmr #(
    parameter int ZHOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       addr,
    input  logic [7:0] din,
    input  logic       zero,
    output logic [7:0] dout,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_inst,
    output logic       up_original,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       busy
);

    localparam int              CW      = (ZHOLD < 1) ? 1 : $clog2(ZHOLD + 1);
    localparam logic [CW-1:0]   C_ZHOLD = CW'(ZHOLD);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   zcnt_q,  zcnt_d;
    logic [7:0]      areg_q,  areg_d;
    logic [7:0]      dout_q,  dout_d;
    logic [1:0]      group_q, group_d;
    logic [2:0]      sub_q,   sub_d;
    // One-hot strobes: [0] original, [1] fnumlo, [2] fnumhi, [3] inst
    logic [3:0]      up_q,    up_d;
    logic            busy_q,  busy_d;
    logic            rhy_en_q,  rhy_en_d;
    logic [4:0]      rhy_kon_q, rhy_kon_d;
    logic            wact_q,  wact_d;

    logic            w_wr_act;
    logic            w_wr_edge;
    logic            w_data_wr;
    logic [3:0]      w_kind;
    logic            w_rhy;
    logic [1:0]      w_grp;
    logic [2:0]      w_sub;

    assign w_wr_act  = ~cs_n & ~wr_n;
    assign w_wr_edge = w_wr_act & ~wact_q;
    assign w_data_wr = w_wr_edge & addr;

    // Address decode of the latched register number
    always_comb begin
        w_kind = 4'b0000;
        w_rhy  = 1'b0;
        w_grp  = 2'd0;
        w_sub  = 3'd0;
        case (areg_q[7:4])
            4'h0: begin
                if (!areg_q[3]) begin
                    w_kind = 4'b0001;
                    w_sub  = areg_q[2:0];
                end else if (areg_q[3:0] == 4'hE) begin
                    w_rhy = 1'b1;
                end
            end
            4'h1, 4'h2, 4'h3: begin
                if (areg_q[3:0] <= 4'd8) begin
                    w_kind = 4'b0001 << areg_q[5:4];
                    case (areg_q[3:0])
                        4'd0, 4'd1, 4'd2: begin
                            w_grp = 2'd0;
                            w_sub = 3'(areg_q[3:0]);
                        end
                        4'd3, 4'd4, 4'd5: begin
                            w_grp = 2'd1;
                            w_sub = 3'(areg_q[3:0] - 4'd3);
                        end
                        default: begin
                            w_grp = 2'd2;
                            w_sub = 3'(areg_q[3:0] - 4'd6);
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        zcnt_d    = zcnt_q;
        areg_d    = areg_q;
        dout_d    = dout_q;
        group_d   = group_q;
        sub_d     = sub_q;
        up_d      = up_q;
        busy_d    = busy_q;
        rhy_en_d  = rhy_en_q;
        rhy_kon_d = rhy_kon_q;
        wact_d    = w_wr_act;

        if (w_wr_edge && !addr) begin
            areg_d = din;
        end

        // Rhythm writes bypass the hold machine entirely
        if (w_data_wr && w_rhy) begin
            rhy_en_d  = din[5];
            rhy_kon_d = din[4:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (w_data_wr && (w_kind != 4'b0000)) begin
                    dout_d  = din;
                    group_d = w_grp;
                    sub_d   = w_sub;
                    up_d    = w_kind;
                    busy_d  = 1'b1;
                    zcnt_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cen && zero) begin
                    if (zcnt_q + CW'(1) == C_ZHOLD) begin
                        up_d    = 4'b0000;
                        busy_d  = 1'b0;
                        zcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        zcnt_d  = zcnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            zcnt_q    <= '0;
            areg_q    <= 8'h00;
            dout_q    <= 8'h00;
            group_q   <= 2'd0;
            sub_q     <= 3'd0;
            up_q      <= 4'b0000;
            busy_q    <= 1'b0;
            rhy_en_q  <= 1'b0;
            rhy_kon_q <= 5'd0;
            wact_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            zcnt_q    <= zcnt_d;
            areg_q    <= areg_d;
            dout_q    <= dout_d;
            group_q   <= group_d;
            sub_q     <= sub_d;
            up_q      <= up_d;
            busy_q    <= busy_d;
            rhy_en_q  <= rhy_en_d;
            rhy_kon_q <= rhy_kon_d;
            wact_q    <= wact_d;
        end
    end

    assign dout        = dout_q;
    assign sel_group   = group_q;
    assign sel_sub     = sub_q;
    assign up_original = up_q[0];
    assign up_fnumlo   = up_q[1];
    assign up_fnumhi   = up_q[2];
    assign up_inst     = up_q[3];
    assign busy        = busy_q;
    assign rhy_en      = rhy_en_q;
    assign rhy_kon     = rhy_kon_q;

endmodule
`default_nettype wire

// File: tb/tb_jtopll_mmr.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module      : tb_jtopll_mmr
// Description : Scoreboard bench for jtopll_mmr with a register-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_jtopll_mmr;

    localparam int ZHOLD = 2;

    logic       clk = 1'b0;
    logic       rst, cen, cs_n, wr_n, addr, zero;
    logic [7:0] din;
    logic [7:0] dout;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_fnumlo, up_fnumhi, up_inst, up_original, rhy_en, busy;
    logic [4:0] rhy_kon;
    logic [3:0] strobes;

    assign strobes = {up_inst, up_fnumhi, up_fnumlo, up_original};

    jtopll_mmr #(.ZHOLD(ZHOLD)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr),
        .din(din), .zero(zero), .dout(dout), .sel_group(sel_group), .sel_sub(sel_sub),
        .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst),
        .up_original(up_original), .rhy_en(rhy_en), .rhy_kon(rhy_kon), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // kind: 0 original, 1 fnumlo, 2 fnumhi, 3 inst
    typedef struct {
        int kind;
        int dv;
        int grp;
        int sub;
    } exp_t;

    exp_t sbq[$];
    int   rhyq[$];

    bit m_prev;
    int m_addr;
    bit m_busy;
    int m_rem;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_prev = 1'b0;
        m_addr = 0;
        m_busy = 1'b0;
        m_rem  = 0;
        sbq.delete();
        rhyq.delete();
    endfunction

    // One clock cycle of stimulus; the model predicts the effect of the coming edge.
    task automatic tick(input bit c, input bit w, input bit a, input int d, input bit ce, input bit z);
        bit act, old_busy;
        int hi, lo;
        @(negedge clk);
        cs_n = c; wr_n = w; addr = a; din = 8'(d); cen = ce; zero = z;
        act      = !c && !w;
        old_busy = m_busy;
        if (old_busy && ce && z) begin
            m_rem--;
            if (m_rem == 0) m_busy = 1'b0;
        end
        if (act && !m_prev) begin
            if (!a) begin
                m_addr = d & 255;
            end else begin
                hi = m_addr / 16;
                lo = m_addr % 16;
                if (m_addr == 'h0E) begin
                    rhyq.push_back(d & 63);
                end else if (!old_busy) begin
                    if (m_addr < 8) begin
                        sbq.push_back('{0, d & 255, 0, m_addr});
                        m_busy = 1'b1;
                        m_rem  = ZHOLD;
                    end else if (hi >= 1 && hi <= 3 && lo <= 8) begin
                        sbq.push_back('{hi, d & 255, lo / 3, lo % 3});
                        m_busy = 1'b1;
                        m_rem  = ZHOLD;
                    end
                end
            end
        end
        m_prev = act;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input bit a, input int d);
        tick(1'b0, 1'b0, a, d, 1'b0, 1'b0);
        tick(1'b1, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic zpulses(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic do_reset_async();
        @(negedge clk);
        #2;
        rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; cen = 1'b0; zero = 1'b0;
        #1;
        chk("rst_strobes", int'(strobes), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_rhy_en",  int'(rhy_en),  0);
        chk("rst_rhy_kon", int'(rhy_kon), 0);
        chk("rst_dout",    int'(dout),    0);
        chk("rst_sel",     int'({sel_group, sel_sub}), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops an expected update whenever busy rises, tracks hold length.
    initial begin : monitor
        bit   in_hold;
        bit   qz;
        int   zc;
        int   rexp;
        exp_t cur;
        in_hold = 1'b0; zc = 0; rexp = 0; cur = '{0, 0, 0, 0};
        forever begin
            @(posedge clk);
            qz = cen && zero;
            #1;
            if (rst) begin
                in_hold = 1'b0; zc = 0; rexp = 0; cur = '{0, 0, 0, 0};
                continue;
            end
            if (rhyq.size() > 0) rexp = rhyq.pop_front();
            chk("rhythm", int'({rhy_en, rhy_kon}), rexp);
            if (in_hold) begin
                if (qz) zc++;
                if (zc == ZHOLD) begin
                    in_hold = 1'b0;
                    chk("release_busy",   int'(busy),    0);
                    chk("release_strobe", int'(strobes), 0);
                end else begin
                    chk("hold_busy",   int'(busy),    1);
                    chk("hold_strobe", int'(strobes), 1 << cur.kind);
                end
            end else if (busy) begin
                in_hold = 1'b1;
                zc      = 0;
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", int'(busy), 0);
                    cur = '{0, int'(dout), int'(sel_group), int'(sel_sub)};
                end else begin
                    cur = sbq.pop_front();
                    chk("strobe", int'(strobes), 1 << cur.kind);
                end
            end else begin
                chk("idle_strobes", int'(strobes), 0);
            end
            chk("dout",      int'(dout),      cur.dv);
            chk("sel_group", int'(sel_group), cur.grp);
            chk("sel_sub",   int'(sel_sub),   cur.sub);
        end
    end

    initial begin : stim
        int r;
        int a_pick;
        rst = 1'b1; cen = 1'b0; cs_n = 1'b1; wr_n = 1'b1; addr = 1'b0; din = 8'h00; zero = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_strobes", int'(strobes), 0);
        chk("init_busy",    int'(busy),    0);
        chk("init_rhy",     int'({rhy_en, rhy_kon}), 0);
        rst = 1'b0;

        // fnumlo to channel 5
        wr(1'b0, 'h15);
        wr(1'b1, 'hA3);
        chk("d031_fnumlo", int'(up_fnumlo), 1);
        chk("d031_group",  int'(sel_group), 1);
        chk("d031_sub",    int'(sel_sub),   2);
        chk("d031_dout",   int'(dout),      'hA3);
        tick(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        chk("d031_busy_z1", int'(busy), 1);
        tick(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        chk("d031_busy_nocen", int'(busy), 1);
        tick(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        chk("d031_busy_z2", int'(busy), 0);

        // original patch byte 3
        wr(1'b0, 'h03);
        wr(1'b1, 'h7F);
        chk("d032_orig", int'(up_original), 1);
        chk("d032_sel",  int'({sel_group, sel_sub}), 3);
        chk("d032_dout", int'(dout), 'h7F);
        zpulses(2);

        // rhythm
        wr(1'b0, 'h0E);
        wr(1'b1, 'h3F);
        chk("d033_rhy_on", int'({rhy_en, rhy_kon}), 'h3F);
        chk("d033_busy",   int'(busy), 0);
        wr(1'b1, 'h00);
        chk("d033_rhy_off", int'({rhy_en, rhy_kon}), 0);

        // second instrument write while busy is dropped
        wr(1'b0, 'h30);
        wr(1'b1, 'h55);
        wr(1'b0, 'h31);
        wr(1'b1, 'h66);
        chk("d034_dout", int'(dout),    'h55);
        chk("d034_sub",  int'(sel_sub), 0);
        zpulses(2);

        // unmapped address, then a long write pulse
        wr(1'b0, 'h19);
        wr(1'b1, 'h12);
        chk("d035_busy", int'(busy), 0);
        wr(1'b0, 'h12);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b0, 1'b1, 'h44, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("d035_single", int'(busy), 0);

        // reset in the middle of an instrument hold
        wr(1'b0, 'h0E);
        wr(1'b1, 'h20);
        wr(1'b0, 'h38);
        wr(1'b1, 'h9A);
        chk("d036_inst", int'(up_inst), 1);
        do_reset_async();
        wr(1'b0, 'h21);
        wr(1'b1, 'h5C);
        chk("d036_after", int'(up_fnumhi), 1);
        chk("d036_sel",   int'({sel_group, sel_sub}), 1);
        zpulses(2);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      a_pick = 'h0E;
            else if (r == 1) a_pick = $urandom_range(0, 'h45);
            else             a_pick = ($urandom_range(0, 3) * 16) + $urandom_range(0, 10);
            addr = 1'b0;
            if ($urandom_range(0, 1) == 1)
                tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, 1'b0, a_pick,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            else
                tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, 1'b1, $urandom_range(0, 255),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            if ((i % 500) == 499) do_reset_async();
        end

        zpulses(4);
        chk("sb_drained",  sbq.size(),  0);
        chk("rhy_drained", rhyq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
